load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter RAM_BASE, default 16'h1000, SHALL mark the lowest writable RAM byte address.
REQ-002 Parameter IO_BASE, default 16'h2000, SHALL mark the lowest memory-mapped IO address, with RAM being [RAM_BASE, IO_BASE).
REQ-003 CLK  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 RESET  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 req_valid/req_ready  in/out  1/1  SHALL form the pipeline request handshake.
REQ-006 req_write  in  1  SHALL select store (1) or load (0).
REQ-007 req_size  in  1  SHALL select byte (0) or halfword (1).
REQ-008 req_signed  in  1  SHALL select sign-extension of byte loads.
REQ-009 req_addr, req_wdata  in  16 each  SHALL carry the byte address and store data.
REQ-010 rsp_valid/rsp_ready  out/in  1/1  SHALL form the response handshake.
REQ-011 rsp_rdata  out  16  SHALL carry the load result (zero for stores).
REQ-012 rsp_err  out  1  SHALL flag a rejected access.
REQ-013 wmem, memc  out  1 each; DAddress, DataIn  out  16 each  SHALL drive the data-memory port.
REQ-014 DataOut  in  16  SHALL receive the data-memory combinational read data.

Function
REQ-015 The FSM SHALL have the states IDLE, ACC0, ACC1 and RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 On accept (req_valid && req_ready) the unit SHALL register all req_* fields and go to ACC0 next cycle.
REQ-017 ACC0 SHALL drive DAddress=addr, memc=size, DataIn=wdata, and wmem=write&&!err for exactly one cycle; for loads it SHALL capture DataOut at the end of ACC0.
REQ-018 An aligned access SHALL go ACC0->RESP, giving rsp_valid 2 cycles after accept.
REQ-019 A halfword with addr[0]=1 in RAM SHALL be handled per REQ-029/030.
REQ-020 Byte-load results SHALL be DataOut[7:0], zero-extended or, if req_signed, sign-extended from bit 7; halfword loads SHALL return DataOut unchanged.
REQ-021 A store with addr<RAM_BASE SHALL set rsp_err=1 and never assert wmem; loads below RAM_BASE are legal.
REQ-022 In RESP, rsp_valid SHALL be 1 and held with stable data until rsp_ready; the handshake cycle SHALL return the FSM to IDLE.
REQ-023 A new request SHALL not be accepted in the same cycle as a response handshake (no overlap).
REQ-024 Outside ACC0/ACC1, wmem SHALL be 0 and DAddress/DataIn/memc SHALL be 0.

Reset
REQ-025 While RESET=1 the FSM SHALL be in IDLE, with req_ready=1 and rsp_valid, rsp_err, rsp_rdata, wmem, memc, DAddress and DataIn all 0.
REQ-026 A RESET asserted mid-transaction SHALL abort it immediately: no further wmem, and no response after release.
REQ-027 After RESET deasserts, the first accept SHALL be possible on the first rising edge.

Configuration
REQ-028 The macro LSU_MISALIGN_SPLIT_EN SHALL select misaligned-halfword handling.
REQ-029 With LSU_MISALIGN_SPLIT_EN defined, a misaligned halfword SHALL split into two byte accesses, memc=0 for both:
- ACC0 SHALL access addr with data byte [7:0].
- ACC1 SHALL access addr+1 with data byte [15:8].
- The load result SHALL be {ACC1 byte, ACC0 byte}.
- rsp_valid SHALL follow 3 cycles after accept.
REQ-030 Without LSU_MISALIGN_SPLIT_EN, a misaligned halfword SHALL set rsp_err=1, SHALL not assert wmem, SHALL return rsp_rdata=0, and SHALL take aligned latency.

Structure
REQ-031 A shared package lsu_pkg SHALL hold the FSM state enum, the SIZE_BYTE/SIZE_HALF constants and the RAM_BASE/IO_BASE defaults.
REQ-032 One sub-module, lsu_load_align, SHALL perform byte select, sign/zero extension and halfword merge combinationally.

Verification
REQ-033 Store half 16'hBEEF at 16'h1004, then load half at 16'h1004 -> rsp_rdata=16'hBEEF, one wmem pulse with memc=1, rsp 2 cycles after accept.
REQ-034 Store byte 8'h80 at 16'h1010, then load byte with req_signed=1 and again with req_signed=0 -> 16'hFF80, then 16'h0080.
REQ-035 Store half 16'h1234 at 16'h1005 -> with the macro: two wmem pulses, (1005,34) then (1006,12), rsp at 3 cycles, err=0; without the macro: no wmem, rsp_err=1.
REQ-036 Store at 16'h0800 -> no wmem, rsp_err=1; load at 16'h0800 -> returns DataOut, rsp_err=0.
REQ-037 Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable and req_ready=0 throughout; assert RESET in ACC1 -> no second wmem and no rsp_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, access sizes
// and default RAM / memory-mapped IO region bases.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_HALF = 1'b1;

    localparam logic [15:0] RAM_BASE_DEFAULT = 16'h1000;
    localparam logic [15:0] IO_BASE_DEFAULT  = 16'h2000;

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: byte select with sign/zero extension, halfword
// pass-through, and the merge of two byte reads into one halfword.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [15:0] mem_data,
    input  logic        size,
    input  logic        sign_ext,
    input  logic        merge,
    input  logic [7:0]  lo_byte,
    output logic [15:0] rdata
);

    always_comb begin
        rdata = 16'h0000;
        if (merge) begin
            // Second half of a split access: this read is the upper byte.
            rdata = {mem_data[7:0], lo_byte};
        end else if (size == SIZE_HALF) begin
            rdata = mem_data;
        end else if (sign_ext) begin
            rdata = {{8{mem_data[7]}}, mem_data[7:0]};
        end else begin
            rdata = {8'h00, mem_data[7:0]};
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// 16-bit load/store unit between a pipeline request/response port and a data memory.
// Build option LSU_MISALIGN_SPLIT_EN: misaligned RAM halfwords become two byte accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter logic [15:0] RAM_BASE = RAM_BASE_DEFAULT,
    parameter logic [15:0] IO_BASE  = IO_BASE_DEFAULT
) (
    input  logic        CLK,
    input  logic        RESET,
    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // a producer holds valid and its payload stable until that edge.
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_size,
    input  logic        req_signed,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        wmem,
    output logic        memc,
    output logic [15:0] DAddress,
    output logic [15:0] DataIn,
    input  logic [15:0] DataOut,
    output logic [1:0]  state_dbg
);

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam logic SPLIT_EN = 1'b1;
`else
    localparam logic SPLIT_EN = 1'b0;
`endif

    lsu_state_e  state_q, state_d;
    logic [15:0] addr_q, addr_d, wdata_q, wdata_d;
    logic        write_q, write_d, size_q, size_d, signed_q, signed_d;
    logic        err_q, err_d, split_q, split_d;
    logic [7:0]  lo_byte_q, lo_byte_d;
    logic        rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [15:0] rsp_rdata_q, rsp_rdata_d;
    logic        wmem_q, wmem_d, memc_q, memc_d;
    logic [15:0] daddr_q, daddr_d, datain_q, datain_d;

    logic        req_misal, req_in_ram, req_split, req_err;
    logic [15:0] align_rdata;

    lsu_load_align u_align (
        .mem_data (DataOut),
        .size     (size_q),
        .sign_ext (signed_q),
        .merge    (state_q == ST_ACC1),
        .lo_byte  (lo_byte_q),
        .rdata    (align_rdata)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        write_d     = write_q;
        size_d      = size_q;
        signed_d    = signed_q;
        err_d       = err_q;
        split_d     = split_q;
        lo_byte_d   = lo_byte_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        wmem_d      = wmem_q;
        memc_d      = memc_q;
        daddr_d     = daddr_q;
        datain_d    = datain_q;

        // Splitting is confined to RAM so an IO register never sees a torn halfword.
        req_misal  = (req_size == SIZE_HALF) && req_addr[0];
        req_in_ram = (req_addr >= RAM_BASE) && (req_addr < IO_BASE);
        req_split  = SPLIT_EN && req_misal && req_in_ram;
        req_err    = (req_write && (req_addr < RAM_BASE)) || (req_misal && !req_split);

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d     = ST_ACC0;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    write_d     = req_write;
                    size_d      = req_size;
                    signed_d    = req_signed;
                    err_d       = req_err;
                    split_d     = req_split;
                    rsp_rdata_d = 16'h0000;
                    wmem_d      = req_write && !req_err;
                    memc_d      = req_split ? SIZE_BYTE : req_size;
                    daddr_d     = req_addr;
                    datain_d    = req_split ? {8'h00, req_wdata[7:0]} : req_wdata;
                end
            end
            ST_ACC0: begin
                if (!write_q && !err_q) begin
                    if (split_q) lo_byte_d = DataOut[7:0];
                    else         rsp_rdata_d = align_rdata;
                end
                if (split_q) begin
                    state_d  = ST_ACC1;
                    wmem_d   = write_q;
                    memc_d   = SIZE_BYTE;
                    daddr_d  = addr_q + 16'd1;
                    datain_d = {8'h00, wdata_q[15:8]};
                end else begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_q;
                    wmem_d      = 1'b0;
                    memc_d      = 1'b0;
                    daddr_d     = 16'h0000;
                    datain_d    = 16'h0000;
                end
            end
            ST_ACC1: begin
                if (!write_q) rsp_rdata_d = align_rdata;
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = err_q;
                wmem_d      = 1'b0;
                memc_d      = 1'b0;
                daddr_d     = 16'h0000;
                datain_d    = 16'h0000;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = 16'h0000;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            addr_q      <= 16'h0000;
            wdata_q     <= 16'h0000;
            write_q     <= 1'b0;
            size_q      <= 1'b0;
            signed_q    <= 1'b0;
            err_q       <= 1'b0;
            split_q     <= 1'b0;
            lo_byte_q   <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 16'h0000;
            wmem_q      <= 1'b0;
            memc_q      <= 1'b0;
            daddr_q     <= 16'h0000;
            datain_q    <= 16'h0000;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            err_q       <= err_d;
            split_q     <= split_d;
            lo_byte_q   <= lo_byte_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            wmem_q      <= wmem_d;
            memc_q      <= memc_d;
            daddr_q     <= daddr_d;
            datain_q    <= datain_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign wmem      = wmem_q;
    assign memc      = memc_q;
    assign DAddress  = daddr_q;
    assign DataIn    = datain_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array data memory, transaction-level reference
// memory and write scoreboard; directed cases followed by randomized traffic.
module tb_load_store_unit;

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif
    localparam logic [15:0] RAM_BASE = 16'h1000;
    localparam logic [15:0] IO_BASE  = 16'h2000;

    logic        clk = 1'b0;
    logic        RESET;
    logic        req_valid, req_ready, req_write, req_size, req_signed;
    logic [15:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [15:0] rsp_rdata;
    logic        wmem, memc;
    logic [15:0] DAddress, DataIn, DataOut;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  mem [0:65535];
    logic [7:0]  model_mem [0:65535];
    logic        mem_ready = 1'b0;
    logic [15:0] daddr_p1;
    logic [32:0] exp_q[$];
    logic [32:0] obs_q[$];
    int          obs_rd = 0;

    load_store_unit dut (
        .CLK(clk), .RESET(RESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .wmem(wmem), .memc(memc),
        .DAddress(DAddress), .DataIn(DataIn), .DataOut(DataOut), .state_dbg(state_dbg)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    function automatic logic [7:0] init_byte(input int i);
        return 8'(i * 37 + 91);
    endfunction

    // Data memory: combinational read, write on rising edge
    assign daddr_p1 = DAddress + 16'd1;
    assign DataOut  = {mem[daddr_p1], mem[DAddress]};

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 65536; i++) mem[i] <= init_byte(i);
            mem_ready <= 1'b1;
        end else if (wmem) begin
            mem[DAddress] <= DataIn[7:0];
            if (memc) mem[daddr_p1] <= DataIn[15:8];
        end
    end

    // Write monitor: record each wmem pulse as {memc, addr, data}
    always @(negedge clk) begin
        if (!RESET && wmem)
            obs_q.push_back({memc, DAddress, memc ? DataIn : {8'h00, DataIn[7:0]}});
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_writes();
        logic [32:0] o, e;
        chk("write_count", 16'(obs_q.size() - obs_rd), 16'(exp_q.size()));
        while (obs_rd < obs_q.size() && exp_q.size() > 0) begin
            o = obs_q[obs_rd];
            obs_rd++;
            e = exp_q.pop_front();
            chk("w_memc", 16'(o[32]), 16'(e[32]));
            chk("w_addr", o[31:16], e[31:16]);
            chk("w_data", o[15:0], e[15:0]);
        end
        obs_rd = obs_q.size();
        exp_q.delete();
    endtask

    // Driver + reference: one complete transaction, response held for 'hold' cycles
    task automatic do_txn(input logic w, input logic sz, input logic sg,
                          input logic [15:0] a, input logic [15:0] wd,
                          input int hold, input bit no_wait);
        logic [15:0] a1 = a + 16'd1;
        logic        misal, in_ram, split, err;
        logic [15:0] exp_rd;
        int          lat, cyc;

        misal  = sz && a[0];
        in_ram = (a >= RAM_BASE) && (a < IO_BASE);
        split  = SPLIT && misal && in_ram;
        err    = (w && (a < RAM_BASE)) || (misal && !split);
        lat    = split ? 3 : 2;

        if (w || err)    exp_rd = 16'h0000;
        else if (sz)     exp_rd = {model_mem[a1], model_mem[a]};
        else if (sg)     exp_rd = {{8{model_mem[a][7]}}, model_mem[a]};
        else             exp_rd = {8'h00, model_mem[a]};

        if (w && !err) begin
            if (split) begin
                exp_q.push_back({1'b0, a,  8'h00, wd[7:0]});
                exp_q.push_back({1'b0, a1, 8'h00, wd[15:8]});
                model_mem[a]  = wd[7:0];
                model_mem[a1] = wd[15:8];
            end else if (sz) begin
                exp_q.push_back({1'b1, a, wd});
                model_mem[a]  = wd[7:0];
                model_mem[a1] = wd[15:8];
            end else begin
                exp_q.push_back({1'b0, a, 8'h00, wd[7:0]});
                model_mem[a] = wd[7:0];
            end
        end

        if (!no_wait) @(negedge clk);
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        chk("req_ready_idle", 16'(req_ready), 16'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid  = 1'b0;
        req_write  = 1'($urandom_range(0, 1));
        req_size   = 1'($urandom_range(0, 1));
        req_signed = 1'($urandom_range(0, 1));
        req_addr   = 16'($urandom);
        req_wdata  = 16'($urandom);

        cyc = 1;
        while (!rsp_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("rsp_latency", 16'(cyc), 16'(lat));
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_err", 16'(rsp_err), 16'(err));

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 16'(rsp_valid), 16'd1);
            chk("hold_rdata", rsp_rdata, exp_rd);
            chk("hold_err", 16'(rsp_err), 16'(err));
            chk("hold_req_ready", 16'(req_ready), 16'd0);
            chk("idle_wmem", 16'(wmem), 16'd0);
            chk("idle_daddr", DAddress, 16'h0000);
            chk("idle_datain", DataIn, 16'h0000);
        end

        rsp_ready = 1'b1;
        chk("hs_req_ready", 16'(req_ready), 16'd0);
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_done", 16'(rsp_valid), 16'd0);
        chk("ready_back", 16'(req_ready), 16'd1);
        check_writes();
    endtask

    // Reset while a store is in flight: first access lands, nothing after it
    task automatic reset_mid();
        logic [15:0] a = SPLIT ? 16'h1015 : 16'h1014;
        logic [15:0] a1 = a + 16'd1;
        if (SPLIT) begin
            exp_q.push_back({1'b0, a, 16'h005A});
            model_mem[a] = 8'h5A;
        end else begin
            exp_q.push_back({1'b1, a, 16'hA55A});
            model_mem[a]  = 8'h5A;
            model_mem[a1] = 8'hA5;
        end
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_size   = 1'b1;
        req_signed = 1'b0;
        req_addr   = a;
        req_wdata  = 16'hA55A;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #1 RESET = 1'b1;
        #1;
        chk("rst_wmem", 16'(wmem), 16'd0);
        chk("rst_rsp_valid", 16'(rsp_valid), 16'd0);
        chk("rst_req_ready", 16'(req_ready), 16'd1);
        chk("rst_daddr", DAddress, 16'h0000);
        repeat (2) @(negedge clk);
        RESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_rsp_valid", 16'(rsp_valid), 16'd0);
            chk("post_rst_req_ready", 16'(req_ready), 16'd1);
        end
        check_writes();
    endtask

    initial begin
        logic [15:0] base;
        int          region;

        for (int i = 0; i < 65536; i++) model_mem[i] = init_byte(i);
        RESET      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 1'b0;
        req_signed = 1'b0;
        req_addr   = 16'h0000;
        req_wdata  = 16'h0000;
        rsp_ready  = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_req_ready", 16'(req_ready), 16'd1);
        chk("reset_rsp_valid", 16'(rsp_valid), 16'd0);
        chk("reset_rsp_err", 16'(rsp_err), 16'd0);
        chk("reset_rsp_rdata", rsp_rdata, 16'h0000);
        chk("reset_wmem", 16'(wmem), 16'd0);
        chk("reset_memc", 16'(memc), 16'd0);
        chk("reset_daddr", DAddress, 16'h0000);
        chk("reset_datain", DataIn, 16'h0000);

        // Release and issue a request in the same cycle: accepted on the first edge
        RESET = 1'b0;
        do_txn(1'b1, 1'b1, 1'b0, 16'h1004, 16'hBEEF, 0, 1'b1);
        do_txn(1'b0, 1'b1, 1'b0, 16'h1004, 16'h0000, 1, 1'b0);
        do_txn(1'b1, 1'b0, 1'b0, 16'h1010, 16'h0080, 0, 1'b0);
        do_txn(1'b0, 1'b0, 1'b1, 16'h1010, 16'h0000, 0, 1'b0);
        do_txn(1'b0, 1'b0, 1'b0, 16'h1010, 16'h0000, 0, 1'b0);
        do_txn(1'b1, 1'b1, 1'b0, 16'h1005, 16'h1234, 0, 1'b0);
        do_txn(1'b0, 1'b1, 1'b0, 16'h1005, 16'h0000, 0, 1'b0);
        do_txn(1'b1, 1'b1, 1'b0, 16'h0800, 16'h5555, 0, 1'b0);
        do_txn(1'b0, 1'b1, 1'b0, 16'h0800, 16'h0000, 0, 1'b0);
        do_txn(1'b0, 1'b1, 1'b0, 16'h1004, 16'h0000, 5, 1'b0);
        reset_mid();
        do_txn(1'b0, 1'b1, 1'b0, 16'h1014, 16'h0000, 0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            region = $urandom_range(0, 3);
            case (region)
                0:       base = 16'h0800;
                1:       base = 16'h1000;
                2:       base = 16'h1FF8;
                default: base = 16'h2000;
            endcase
            do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), base + 16'($urandom_range(0, 15)),
                   16'($urandom), $urandom_range(0, 3), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
